// File: rtl/fb_stim_gen_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the PLL feedback stimulus generator.
// Mode codes, FSM state encoding and the default phase-kick offset.
// Purely declarative; no logic of its own.
package fb_stim_gen_pkg;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_SWEEP = 2'd1;

    // 90 degrees of a 16-bit phase accumulator
    localparam int unsigned PHASE_KICK_DEF = 32'h0000_4000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONST    = 3'd1,
        ST_SWEEP_UP = 3'd2,
        ST_SWEEP_DN = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    // States in which the accumulator advances and fb_out may toggle
    function automatic logic is_running(input state_t s);
        return (s == ST_CONST) || (s == ST_SWEEP_UP) || (s == ST_SWEEP_DN);
    endfunction

endpackage

// File: rtl/fb_stim_gen_nco.sv
`timescale 1ns/1ps
// Purpose: phase accumulator NCO producing the fb_out square wave and a rising-edge tick.
// Latency: fb_out / period_tick registered, 1 cycle after the accumulate they reflect.
// Backpressure: none; run=0 holds the accumulator and forces fb_out low.
module nco_core
    import fb_stim_gen_pkg::*;
#(
    parameter int          ACC_BITS   = 16,
    parameter int          FREQ_BITS  = 10,
    parameter int unsigned PHASE_KICK = PHASE_KICK_DEF
) (
    input  logic                 clk_50,
    input  logic                 rst,
    input  logic                 run,
    input  logic [FREQ_BITS-1:0] freq,
    input  logic                 kick,
    output logic                 fb_out,
    output logic                 period_tick
);

    localparam logic [ACC_BITS-1:0] KICK_OFS = ACC_BITS'(PHASE_KICK);

    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] acc_next;
    logic [ACC_BITS-1:0] freq_ext;
    logic                fb_next;

    // Next phase: hold when stopped, otherwise add the zero-extended word plus optional kick
    always_comb begin
        freq_ext = ACC_BITS'(freq);
        acc_next = acc;
        if (run) begin
            acc_next = acc + freq_ext;
            if (kick) begin
                acc_next = acc_next + KICK_OFS;
            end
        end
        fb_next = run & acc_next[ACC_BITS-1];
    end

    // Accumulator, square-wave output and rising-edge tick registers
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            fb_out      <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            acc         <= acc_next;
            fb_out      <= fb_next;
            period_tick <= fb_next & ~fb_out;
        end
    end

endmodule

// File: rtl/fb_stim_gen.sv
`timescale 1ns/1ps
// Purpose: programmable square-wave source for the PLL feedback input (const, sweep, dropout, kick).
// Latency: mode/frequency changes reach the accumulator in the same edge they are registered.
// Backpressure: none; drop_req while dropping and kicks outside running states are ignored.
module fb_stim_gen
    import fb_stim_gen_pkg::*;
#(
    parameter int          ACC_BITS   = 16,
    parameter int          FREQ_BITS  = 10,
    parameter int unsigned SWEEP_DIV  = 50000,
    parameter int unsigned DROP_CYC   = 100000,
    parameter int unsigned PHASE_KICK = PHASE_KICK_DEF
) (
    input  logic                 clk_50,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [FREQ_BITS-1:0] freq_word,
    input  logic [FREQ_BITS-1:0] sweep_lo,
    input  logic [FREQ_BITS-1:0] sweep_hi,
    input  logic                 drop_req,
    input  logic                 phase_kick,
    output logic                 fb_out,
    output logic [FREQ_BITS-1:0] freq_cur,
    output logic                 dropping,
    output logic                 period_tick
);

    localparam int SW_W = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam int DW   = (DROP_CYC > 1) ? $clog2(DROP_CYC) : 1;
    localparam logic [SW_W-1:0] SW_LAST   = SW_W'(SWEEP_DIV - 1);
    localparam logic [DW-1:0]   DROP_LAST = DW'(DROP_CYC - 1);

    state_t               state, state_nxt, ret_state, ret_state_nxt;
    logic [FREQ_BITS-1:0] freq_nxt, ret_freq, ret_freq_nxt, freq_inc, freq_dec;
    logic [SW_W-1:0]      step_ctr, step_nxt;
    logic [DW-1:0]        drop_ctr, drop_nxt;
    logic                 nco_run, nco_kick;

    // Next-state, frequency and counter logic; enable low overrides everything
    always_comb begin
        state_nxt     = state;
        freq_nxt      = freq_cur;
        step_nxt      = step_ctr;
        drop_nxt      = drop_ctr;
        ret_state_nxt = ret_state;
        ret_freq_nxt  = ret_freq;
        freq_inc      = freq_cur + 1'b1;
        freq_dec      = freq_cur - 1'b1;

        if (!enable) begin
            state_nxt = ST_IDLE;
            freq_nxt  = '0;
            step_nxt  = '0;
            drop_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mode == MODE_SWEEP) begin
                        state_nxt = ST_SWEEP_UP;
                        freq_nxt  = sweep_lo;
                        step_nxt  = '0;
                    end else begin
                        state_nxt = ST_CONST;
                        freq_nxt  = freq_word;
                    end
                end
                ST_CONST, ST_SWEEP_UP, ST_SWEEP_DN: begin
                    if (drop_req) begin
                        state_nxt     = ST_DROP;
                        drop_nxt      = DROP_LAST;
                        ret_state_nxt = state;
                        ret_freq_nxt  = freq_cur;
                    end else if (state == ST_CONST) begin
                        if (mode == MODE_SWEEP) begin
                            state_nxt = ST_SWEEP_UP;
                            freq_nxt  = sweep_lo;
                            step_nxt  = '0;
                        end else begin
                            freq_nxt = freq_word;
                        end
                    end else if (mode != MODE_SWEEP) begin
                        state_nxt = ST_CONST;
                        freq_nxt  = freq_word;
                    end else if (sweep_lo >= sweep_hi) begin
                        // Degenerate range: park on the lower bound
                        state_nxt = ST_SWEEP_UP;
                        freq_nxt  = sweep_lo;
                        step_nxt  = '0;
                    end else begin
                        step_nxt = (step_ctr == SW_LAST) ? '0 : step_ctr + 1'b1;
                        if (step_ctr == SW_LAST) begin
                            // Out-of-range values (bounds moved) clamp to the violated bound
                            if (state == ST_SWEEP_UP) begin
                                if (freq_cur < sweep_lo) begin
                                    freq_nxt = sweep_lo;
                                end else if (freq_cur >= sweep_hi) begin
                                    freq_nxt  = sweep_hi;
                                    state_nxt = ST_SWEEP_DN;
                                end else begin
                                    freq_nxt = freq_inc;
                                    if (freq_inc == sweep_hi) state_nxt = ST_SWEEP_DN;
                                end
                            end else begin
                                if (freq_cur > sweep_hi) begin
                                    freq_nxt = sweep_hi;
                                end else if (freq_cur <= sweep_lo) begin
                                    freq_nxt  = sweep_lo;
                                    state_nxt = ST_SWEEP_UP;
                                end else begin
                                    freq_nxt = freq_dec;
                                    if (freq_dec == sweep_lo) state_nxt = ST_SWEEP_UP;
                                end
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (drop_ctr == '0) begin
                        state_nxt = ret_state;
                        freq_nxt  = ret_freq;
                    end else begin
                        drop_nxt = drop_ctr - 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // The NCO follows the state being entered, so fb_out masking lines up with dropping
        nco_run  = is_running(state_nxt);
        nco_kick = phase_kick & is_running(state);
    end

    // FSM, frequency, counter and saved-context registers
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            freq_cur  <= '0;
            step_ctr  <= '0;
            drop_ctr  <= '0;
            ret_state <= ST_IDLE;
            ret_freq  <= '0;
            dropping  <= 1'b0;
        end else begin
            state     <= state_nxt;
            freq_cur  <= freq_nxt;
            step_ctr  <= step_nxt;
            drop_ctr  <= drop_nxt;
            ret_state <= ret_state_nxt;
            ret_freq  <= ret_freq_nxt;
            dropping  <= (state_nxt == ST_DROP);
        end
    end

    nco_core #(
        .ACC_BITS   (ACC_BITS),
        .FREQ_BITS  (FREQ_BITS),
        .PHASE_KICK (PHASE_KICK)
    ) u_nco (
        .clk_50      (clk_50),
        .rst         (rst),
        .run         (nco_run),
        .freq        (freq_nxt),
        .kick        (nco_kick),
        .fb_out      (fb_out),
        .period_tick (period_tick)
    );

endmodule

// File: tb/tb_fb_stim_gen.sv
`timescale 1ns/1ps
// Directed bench for fb_stim_gen: const timing, freeze, kick, dropout, sweep, clamp, async reset.
module tb_fb_stim_gen;

    logic       clk_50 = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [9:0] freq_word, sweep_lo, sweep_hi;
    logic       drop_req, phase_kick;
    logic       fb_out, dropping, period_tick;
    logic [9:0] freq_cur;

    int checks   = 0;
    int failures = 0;

    fb_stim_gen #(
        .ACC_BITS  (16),
        .FREQ_BITS (10),
        .SWEEP_DIV (4),
        .DROP_CYC  (20)
    ) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .freq_word   (freq_word),
        .sweep_lo    (sweep_lo),
        .sweep_hi    (sweep_hi),
        .drop_req    (drop_req),
        .phase_kick  (phase_kick),
        .fb_out      (fb_out),
        .freq_cur    (freq_cur),
        .dropping    (dropping),
        .period_tick (period_tick)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    int t[5];
    int n, k, high, ticks, dcnt, fb_bad, f, prev, run_len, bad, fmin, fmax, f1, first262, back131;
    logic fb_hold;

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; freq_word = '0;
        sweep_lo = '0; sweep_hi = '0; drop_req = 1'b0; phase_kick = 1'b0;
        #5;
        chk("rst_fb_out", 32'(fb_out), 0);
        chk("rst_freq_cur", 32'(freq_cur), 0);
        chk("rst_dropping", 32'(dropping), 0);
        chk("rst_period_tick", 32'(period_tick), 0);
        step(2);
        rst = 1'b0;

        // CONST 164: ticks at 200, 600, 1000, 1399, 1799
        freq_word = 10'd164; mode = 2'd0; enable = 1'b1;
        foreach (t[i]) t[i] = 0;
        n = 0; high = 0; k = 0;
        while (n < 5 && k < 2000) begin
            step(1); k++;
            if (period_tick) begin t[n] = k; n++; end
            if (n == 4) high += int'(fb_out);
        end
        chk("const_first_tick", 32'(t[0]), 200);
        chk("const_gap1", 32'(t[1] - t[0]), 400);
        chk("const_gap2", 32'(t[2] - t[1]), 400);
        chk("const_gap3", 32'(t[3] - t[2]), 399);
        chk("const_gap4", 32'(t[4] - t[3]), 400);
        chk("const_high_cycles", 32'(high), 200);
        chk("const_freq_cur", 32'(freq_cur), 164);

        // freq_word=0 freezes fb_out (currently high)
        fb_hold = fb_out;
        chk("freeze_start_high", 32'(fb_hold), 1);
        freq_word = 10'd0; ticks = 0; fb_bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (period_tick) ticks++;
            if (fb_out !== fb_hold) fb_bad++;
        end
        chk("freeze_ticks", 32'(ticks), 0);
        chk("freeze_changes", 32'(fb_bad), 0);

        // reserved mode 2 behaves as CONST
        mode = 2'd2; freq_word = 10'd100;
        step(2);
        chk("mode2_freq_cur", 32'(freq_cur), 100);

        // Phase kick from acc=0
        rst = 1'b1; step(1); rst = 1'b0;
        mode = 2'd0; freq_word = 10'd0; enable = 1'b1;
        step(3);
        chk("kick_acc_pre", 32'(dut.u_nco.acc), 0);
        freq_word = 10'd164; phase_kick = 1'b1;
        step(1);
        phase_kick = 1'b0;
        chk("kick_acc", 32'(dut.u_nco.acc), 32'h40A4);
        k = 1;
        while (!period_tick && k < 500) begin step(1); k++; end
        chk("kick_first_tick", 32'(k), 100);

        // Drop + kick in the same cycle, retrigger and kick during DROP ignored
        rst = 1'b1; step(1); rst = 1'b0;
        freq_word = 10'd164; mode = 2'd0; enable = 1'b1;
        step(10);
        chk("drop_acc_pre", 32'(dut.u_nco.acc), 1640);
        drop_req = 1'b1; phase_kick = 1'b1;
        step(1);
        drop_req = 1'b0; phase_kick = 1'b0;
        chk("drop_entered", 32'(dropping), 1);
        chk("drop_fb_low", 32'(fb_out), 0);
        chk("drop_acc_held", 32'(dut.u_nco.acc), 1640);
        dcnt = 1; fb_bad = 0;
        while (dropping && dcnt < 100) begin
            if (dcnt == 5) begin drop_req = 1'b1; phase_kick = 1'b1; end
            step(1);
            drop_req = 1'b0; phase_kick = 1'b0;
            if (dropping) begin dcnt++; if (fb_out) fb_bad++; end
        end
        chk("drop_length", 32'(dcnt), 20);
        chk("drop_fb_high_cycles", 32'(fb_bad), 0);
        chk("drop_acc_resume", 32'(dut.u_nco.acc), 1804);
        chk("drop_freq_restored", 32'(freq_cur), 164);

        // Async reset mid-DROP
        drop_req = 1'b1; step(1); drop_req = 1'b0;
        step(3);
        chk("drop2_active", 32'(dropping), 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_drop_dropping", 32'(dropping), 0);
        chk("rst_mid_drop_freq", 32'(freq_cur), 0);
        chk("rst_mid_drop_fb", 32'(fb_out), 0);
        step(1);
        rst = 1'b0;

        // Ping-pong sweep 131..262..131, 4 cycles per step
        mode = 2'd1; sweep_lo = 10'd131; sweep_hi = 10'd262;
        fmin = 1023; fmax = 0; bad = 0; run_len = 0; prev = 0;
        f1 = 0; first262 = 0; back131 = 0;
        for (int i = 1; i <= 1100; i++) begin
            step(1);
            f = int'(freq_cur);
            if (i == 1) f1 = f;
            if (f < fmin) fmin = f;
            if (f > fmax) fmax = f;
            if (i > 1 && f != prev) begin
                if (f != prev + 1 && f + 1 != prev) bad++;
                if (run_len != 4) bad++;
                run_len = 0;
            end
            run_len++;
            if (f == 262 && first262 == 0) first262 = i;
            if (first262 != 0 && f == 131 && back131 == 0) back131 = i;
            prev = f;
        end
        chk("sweep_start", 32'(f1), 131);
        chk("sweep_min", 32'(fmin), 131);
        chk("sweep_max", 32'(fmax), 262);
        chk("sweep_bad_steps", 32'(bad), 0);
        chk("sweep_reach_hi", 32'(first262), 525);
        chk("sweep_back_lo", 32'(back131), 1049);

        // Upper bound lowered below freq_cur (~143): clamp to 140, then step down
        sweep_hi = 10'd140;
        prev = int'(freq_cur); k = 0;
        while (int'(freq_cur) == prev && k < 10) begin step(1); k++; end
        chk("clamp_value", 32'(freq_cur), 140);
        prev = int'(freq_cur); k = 0;
        while (int'(freq_cur) == prev && k < 10) begin step(1); k++; end
        chk("clamp_then_down", 32'(freq_cur), 139);

        // Async reset mid-SWEEP, then IDLE while enable is low
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_sweep_freq", 32'(freq_cur), 0);
        chk("rst_mid_sweep_fb", 32'(fb_out), 0);
        chk("rst_mid_sweep_tick", 32'(period_tick), 0);
        enable = 1'b0;
        step(2);
        rst = 1'b0;
        step(3);
        chk("idle_freq", 32'(freq_cur), 0);
        chk("idle_fb", 32'(fb_out), 0);

        // Degenerate sweep range parks on sweep_lo
        sweep_lo = 10'd300; sweep_hi = 10'd200; mode = 2'd1; enable = 1'b1;
        step(20);
        chk("flat_sweep_freq", 32'(freq_cur), 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
